// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit sitting behind the control unit of the 16-bit core.
// Runs one data-memory transaction at a time over a req/gnt/rvalid handshake,
// stalls the pipeline while it is in flight, returns load data for writeback,
// and pulses err_o for misaligned or timed-out accesses.
module lsu_ctrl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              load_valid_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              err_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i
);

  // Counter only has to reach TIMEOUT_CYCLES-1, so log2 bits suffice (T >= 2).
  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                load_valid_q, load_valid_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic                err_q, err_d;

  logic                cmd;
  logic                expired;

  // A simultaneous read and write is treated as a read; the write is dropped.
  assign cmd     = mem_read_i | mem_write_i;
  assign expired = (cnt_q == CNT_MAX);

  // Next-state, next-output and combinational stall computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    err_d        = 1'b0;
    stall_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd) begin
          stall_o = 1'b1;
          if (addr_i[0]) begin
            // Misaligned halfword: report and skip the bus entirely.
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = ~mem_read_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            cnt_d   = '0;
          end
        end
      end

      REQ: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // A grant on the expiry cycle still counts as success.
        if (dmem_gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT;
        end else if (expired) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      WAIT: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        // rvalid on the expiry cycle still counts as success.
        if (dmem_rvalid_i) begin
          load_data_d  = dmem_rdata_i;
          load_valid_d = 1'b1;
          state_d      = DONE;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        // The command still presented here belongs to the finishing instruction.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset clears everything.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      err_q        <= err_d;
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign load_valid_o = load_valid_q;
  assign load_data_o  = load_data_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a short timeout (4 cycles).
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_ni;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        stall;
  logic        load_valid;
  logic [15:0] load_data;
  logic        err;
  logic        req;
  logic        we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        gnt;
  logic        rvalid;
  logic [15:0] rdata;

  int tests;
  int fails;

  lsu_ctrl #(
    .DATA_W(16),
    .ADDR_W(16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .mem_read_i(mem_read),
    .mem_write_i(mem_write),
    .addr_i(addr),
    .wdata_i(wdata),
    .stall_o(stall),
    .load_valid_o(load_valid),
    .load_data_o(load_data),
    .err_o(err),
    .dmem_req_o(req),
    .dmem_we_o(we),
    .dmem_addr_o(dm_addr),
    .dmem_wdata_o(dm_wdata),
    .dmem_gnt_i(gnt),
    .dmem_rvalid_i(rvalid),
    .dmem_rdata_i(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle: just past the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_ni = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; wdata = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    @(posedge clk); cyc();
    chk("rst_req", req, 0); chk("rst_we", we, 0); chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0); chk("rst_lv", load_valid, 0);
    chk("rst_ldata", load_data, 0); chk("rst_err", err, 0); chk("rst_stall", stall, 0);
    rst_ni = 1'b1;

    // Load, zero-wait
    mem_read = 1; addr = 16'h0010; #1;
    chk("ld_c0_stall", stall, 1); chk("ld_c0_req", req, 0);
    cyc(); gnt = 1; #1;
    chk("ld_c1_req", req, 1); chk("ld_c1_we", we, 0); chk("ld_c1_addr", dm_addr, 16'h0010);
    chk("ld_c1_stall", stall, 1);
    cyc(); gnt = 0; rvalid = 1; rdata = 16'hBEEF; #1;
    chk("ld_c2_req", req, 0); chk("ld_c2_stall", stall, 1); chk("ld_c2_lv", load_valid, 0);
    cyc(); rvalid = 0; mem_read = 0; #1;
    chk("ld_c3_lv", load_valid, 1); chk("ld_c3_data", load_data, 16'hBEEF);
    chk("ld_c3_stall", stall, 0); chk("ld_c3_err", err, 0);
    cyc();
    chk("ld_c4_lv", load_valid, 0); chk("ld_c4_hold", load_data, 16'hBEEF); chk("ld_c4_stall", stall, 0);

    // Store, grant in third REQ cycle
    mem_write = 1; addr = 16'h0020; wdata = 16'h1234; #1;
    chk("st_c0_stall", stall, 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      if (i == 3) gnt = 1;
      #1;
      chk("st_req", req, 1); chk("st_we", we, 1); chk("st_addr", dm_addr, 16'h0020);
      chk("st_wdata", dm_wdata, 16'h1234); chk("st_stall", stall, 1);
    end
    cyc(); gnt = 0; mem_write = 0; #1;
    chk("st_done_req", req, 0); chk("st_done_stall", stall, 0);
    chk("st_done_err", err, 0); chk("st_done_lv", load_valid, 0);
    cyc();
    chk("st_idle_stall", stall, 0); chk("st_idle_err", err, 0);

    // Misaligned
    mem_read = 1; addr = 16'h0011; #1;
    chk("mis_c0_stall", stall, 1); chk("mis_c0_req", req, 0);
    cyc(); mem_read = 0; #1;
    chk("mis_c1_err", err, 1); chk("mis_c1_req", req, 0); chk("mis_c1_stall", stall, 0);
    cyc();
    chk("mis_c2_err", err, 0); chk("mis_c2_req", req, 0);

    // Timeout: no grant ever
    mem_read = 1; addr = 16'h0040; #1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("to_req", req, 1); chk("to_err", err, 0); chk("to_stall", stall, 1);
    end
    cyc(); mem_read = 0; #1;
    chk("to_done_err", err, 1); chk("to_done_req", req, 0); chk("to_done_stall", stall, 0);
    cyc(); rvalid = 1; rdata = 16'hDEAD; #1;
    chk("to_late_req", req, 0); chk("to_late_err", err, 0);
    cyc(); rvalid = 0; #1;
    chk("to_late_lv", load_valid, 0); chk("to_late_data", load_data, 16'hBEEF);

    // rvalid on the exact expiry cycle wins
    mem_read = 1; addr = 16'h0050; #1;
    cyc(); gnt = 1; #1;
    cyc(); gnt = 0; #1;
    cyc(); #1;
    chk("exp_c3_stall", stall, 1);
    cyc(); rvalid = 1; rdata = 16'hCAFE; #1;
    cyc(); rvalid = 0; mem_read = 0; #1;
    chk("exp_lv", load_valid, 1); chk("exp_data", load_data, 16'hCAFE); chk("exp_err", err, 0);
    cyc();

    // Read and write both high: behaves as a read
    mem_read = 1; mem_write = 1; addr = 16'h0060; wdata = 16'hFFFF; #1;
    cyc(); gnt = 1; #1;
    chk("both_req", req, 1); chk("both_we", we, 0);
    cyc(); gnt = 0; rvalid = 1; rdata = 16'h0A0B; #1;
    chk("both_c2_stall", stall, 1);
    cyc(); rvalid = 0; mem_read = 0; mem_write = 0; #1;
    chk("both_lv", load_valid, 1); chk("both_data", load_data, 16'h0A0B);
    cyc();

    // rvalid together with gnt is not accepted
    mem_read = 1; addr = 16'h0070; #1;
    cyc(); gnt = 1; rvalid = 1; rdata = 16'h1111; #1;
    cyc(); gnt = 0; rvalid = 0; #1;
    cyc(); rvalid = 1; rdata = 16'h2222; #1;
    chk("gr_c3_lv", load_valid, 0); chk("gr_c3_stall", stall, 1);
    cyc(); rvalid = 0; mem_read = 0; #1;
    chk("gr_lv", load_valid, 1); chk("gr_data", load_data, 16'h2222);
    cyc();

    // Reset mid-WAIT, then a late rvalid
    mem_read = 1; addr = 16'h0080; wdata = 16'h5555; #1;
    cyc(); gnt = 1; #1;
    cyc(); gnt = 0; rst_ni = 0; #1;
    cyc(); rst_ni = 1; mem_read = 0; rvalid = 1; rdata = 16'h3333; #1;
    chk("rw_req", req, 0); chk("rw_we", we, 0); chk("rw_addr", dm_addr, 0);
    chk("rw_wdata", dm_wdata, 0); chk("rw_lv", load_valid, 0); chk("rw_ldata", load_data, 0);
    chk("rw_err", err, 0); chk("rw_stall", stall, 0);
    cyc(); rvalid = 0; #1;
    chk("rw_late_lv", load_valid, 0); chk("rw_late_req", req, 0);
    // Next load after reset completes normally
    mem_read = 1; addr = 16'h0090; #1;
    cyc(); gnt = 1; #1;
    chk("rn_req", req, 1); chk("rn_addr", dm_addr, 16'h0090);
    cyc(); gnt = 0; rvalid = 1; rdata = 16'h4444; #1;
    cyc(); rvalid = 0; mem_read = 0; #1;
    chk("rn_lv", load_valid, 1); chk("rn_data", load_data, 16'h4444); chk("rn_err", err, 0);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit for the 16-bit core, directly downstream of the control unit.
- Consumes mem_read/mem_write, the ALU-computed address and rs2 store data.
- Runs one data-memory transaction over a req/gnt/rvalid handshake and stalls the pipeline until it completes.
- Returns load data for the WB_MEM writeback path, and flags misaligned or timed-out accesses.

Parameters:
DATA_W, 16, data width of load/store data
ADDR_W, 16, byte address width
TIMEOUT_CYCLES, 16, maximum cycles spent in REQ+WAIT before abort (must be >= 2)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
mem_read_i  in  1  load command from control
mem_write_i  in  1  store command from control
addr_i  in  ADDR_W  effective byte address (ALU result)
wdata_i  in  DATA_W  store data (rs2)
stall_o  out  1  hold pipeline (comb)
load_valid_o  out  1  one-cycle pulse, load_data_o valid
load_data_o  out  DATA_W  returned load data
err_o  out  1  one-cycle pulse: misaligned or timeout
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1=write, 0=read
dmem_addr_o  out  ADDR_W  request address
dmem_wdata_o  out  DATA_W  request write data
dmem_gnt_i  in  1  request accepted this cycle
dmem_rvalid_i  in  1  read data valid
dmem_rdata_i  in  DATA_W  read data

Behaviour:
- States: IDLE, REQ, WAIT, DONE. All state, counters and outputs are registered except stall_o.
- Reset (rst_ni=0 at an edge):
  - state=IDLE; all outputs 0, including dmem_* fields and load_data_o.
  - Reset mid-transaction drops dmem_req_o the next cycle. Any later rvalid is ignored.
- Command: cmd = mem_read_i | mem_write_i. If both are high, treated as a read (write ignored).
- IDLE with cmd:
  - addr_i[0]=1 (misaligned): go to DONE with err_o=1. No memory request.
  - Otherwise: latch addr_i, wdata_i and we=~mem_read_i; go to REQ; clear timeout counter.
- REQ:
  - dmem_req_o=1. dmem_we_o, dmem_addr_o and dmem_wdata_o held stable until gnt.
  - On gnt: a write goes to DONE; a read goes to WAIT. dmem_req_o falls the cycle after gnt.
- WAIT:
  - On rvalid: capture dmem_rdata_i into load_data_o, go to DONE with load_valid_o=1.
  - rvalid in the same cycle as gnt (still in REQ) is not accepted. Read data is expected no earlier than the cycle after gnt.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When count == TIMEOUT_CYCLES-1 and no gnt/rvalid that cycle: go to DONE with err_o=1 and drop dmem_req_o.
  - gnt or rvalid in the same cycle as expiry wins; no error.
- DONE:
  - Lasts exactly one cycle; load_valid_o/err_o are high only here. Then IDLE.
  - cmd is not sampled in DONE: it is the same instruction advancing.
- load_data_o holds its last value until the next load completes.
- stall_o = (IDLE & cmd) | REQ | WAIT. It is 0 in DONE and in IDLE without cmd.
- Back-to-back memory instructions therefore cost one extra cycle (the DONE→IDLE boundary).
- Latency with zero-wait memory (cycle 0 = command presented):
  - Load: load_valid_o in cycle 3.
  - Store: completes in cycle 2 (DONE).
  - Misaligned: err_o in cycle 1.
- rvalid in IDLE, REQ or DONE is ignored. gnt outside REQ is ignored.

Test Plan:
- Load, zero-wait: mem_read_i=1, addr=0x0010; gnt in cycle 1, rvalid with rdata=0xBEEF in cycle 2 -> dmem_req_o=1 only in cycle 1 with we=0 and addr 0x0010; stall_o=1 cycles 0-2; load_valid_o=1 and load_data_o=0xBEEF in cycle 3.
- Store with 3-cycle gnt delay: mem_write_i=1, addr=0x0020, wdata=0x1234 -> req/addr/wdata stable through gnt; DONE one cycle after gnt; err_o=0, load_valid_o=0.
- Misaligned: mem_read_i=1, addr=0x0011 -> dmem_req_o never asserts; err_o=1 in cycle 1; stall_o=1 only in cycle 0.
- Timeout: TIMEOUT_CYCLES=4, gnt never asserts -> err_o=1 after 4 REQ cycles; dmem_req_o=0 afterwards; a later rvalid produces no load_valid_o.
- Edge cases: rvalid on the exact expiry cycle -> load_valid_o, no err_o. Both mem_read_i and mem_write_i high -> request with dmem_we_o=0.
- Reset mid-WAIT: rst_ni=0 for one cycle during WAIT, then rvalid -> all outputs 0 after the reset edge, state IDLE, load_valid_o stays 0; next load completes normally.
